// File: rtl/shift_operand_ctrl.sv
// shift_operand_ctrl: resolves ARM operand-2 shift corner cases locally and sends ordinary 1..31 shifts to an external registered barrel shifter
module shift_operand_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_rm,
  input  logic [1:0]  req_type,
  input  logic        req_is_reg,
  input  logic [4:0]  req_imm,
  input  logic [7:0]  req_rs_amt,
  input  logic        req_carry,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_operand,
  output logic        out_carry,
  output logic [31:0] sh_shift_in,
  output logic [1:0]  sh_shift_type,
  output logic [4:0]  sh_shift_imm,
  output logic        sh_carry_in,
  input  logic [31:0] sh_operand,
  input  logic        sh_carry_out
);
  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, DONE} state_t;
  state_t      state_q, state_d;
  logic [31:0] out_operand_q, out_operand_d;
  logic        out_carry_q, out_carry_d;
  logic [31:0] sh_shift_in_q, sh_shift_in_d;
  logic [1:0]  sh_shift_type_q, sh_shift_type_d;
  logic [4:0]  sh_shift_imm_q, sh_shift_imm_d;
  logic        sh_carry_in_q, sh_carry_in_d;
  logic        accept, is_local, amt_zero, amt_big;
  logic [31:0] loc_op;
  logic        loc_c;
  // Classify the request: cases the shifter cannot encode are resolved here
  always_comb begin
    accept   = req_valid && state_q == IDLE;
    amt_zero = req_rs_amt == 8'd0;
    amt_big  = |req_rs_amt[7:5];
    is_local = req_is_reg ? (amt_zero || (req_type == 2'b11 ? req_rs_amt[4:0] == 5'd0 : amt_big))
                          : (req_type == 2'b00 && req_imm == 5'd0);
    loc_op   = req_rm;
    loc_c    = req_carry;
    if (req_is_reg && !amt_zero) begin
      case (req_type)
        2'b00: begin loc_op = '0; loc_c = req_rs_amt == 8'd32 && req_rm[0]; end
        2'b01: begin loc_op = '0; loc_c = req_rs_amt == 8'd32 && req_rm[31]; end
        2'b10: begin loc_op = {32{req_rm[31]}}; loc_c = req_rm[31]; end
        default: begin loc_op = req_rm; loc_c = req_rm[31]; end
      endcase
    end
  end
  // State and datapath registers, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      out_operand_q   <= '0;
      out_carry_q     <= 1'b0;
      sh_shift_in_q   <= '0;
      sh_shift_type_q <= '0;
      sh_shift_imm_q  <= '0;
      sh_carry_in_q   <= 1'b0;
    end else begin
      state_q         <= state_d;
      out_operand_q   <= out_operand_d;
      out_carry_q     <= out_carry_d;
      sh_shift_in_q   <= sh_shift_in_d;
      sh_shift_type_q <= sh_shift_type_d;
      sh_shift_imm_q  <= sh_shift_imm_d;
      sh_carry_in_q   <= sh_carry_in_d;
    end
  end
  // Next state: local results skip straight to DONE, others go through the shifter
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = accept ? (is_local ? DONE : ISSUE) : IDLE;
      ISSUE:   state_d = CAPTURE;
      CAPTURE: state_d = DONE;
      default: state_d = out_ready ? IDLE : DONE;
    endcase
  end
  // Datapath: load local result or shifter command on accept, sample shifter in CAPTURE
  always_comb begin
    out_operand_d   = out_operand_q;
    out_carry_d     = out_carry_q;
    sh_shift_in_d   = sh_shift_in_q;
    sh_shift_type_d = sh_shift_type_q;
    sh_shift_imm_d  = sh_shift_imm_q;
    sh_carry_in_d   = sh_carry_in_q;
    if (accept && is_local) begin
      out_operand_d = loc_op;
      out_carry_d   = loc_c;
    end
    if (accept && !is_local) begin
      sh_shift_in_d   = req_rm;
      sh_shift_type_d = req_type;
      sh_shift_imm_d  = req_is_reg ? req_rs_amt[4:0] : req_imm;
      sh_carry_in_d   = req_carry;
    end
    if (state_q == CAPTURE) begin
      out_operand_d = sh_operand;
      out_carry_d   = sh_carry_out;
    end
  end
  // Outputs decoded from state and registers
  always_comb begin
    req_ready     = state_q == IDLE;
    out_valid     = state_q == DONE;
    out_operand   = out_operand_q;
    out_carry     = out_carry_q;
    sh_shift_in   = sh_shift_in_q;
    sh_shift_type = sh_shift_type_q;
    sh_shift_imm  = sh_shift_imm_q;
    sh_carry_in   = sh_carry_in_q;
  end
endmodule

// File: tb/tb_shift_operand_ctrl.sv
// tb_shift_operand_ctrl: directed checks of shift_operand_ctrl against a registered ARM barrel shifter model
module tb_shift_operand_ctrl;
  logic        clk = 0;
  logic        rst_n = 0;
  logic        req_valid = 0;
  logic        req_ready;
  logic [31:0] req_rm = 0;
  logic [1:0]  req_type = 0;
  logic        req_is_reg = 0;
  logic [4:0]  req_imm = 0;
  logic [7:0]  req_rs_amt = 0;
  logic        req_carry = 0;
  logic        out_valid;
  logic        out_ready = 0;
  logic [31:0] out_operand;
  logic        out_carry;
  logic [31:0] sh_shift_in;
  logic [1:0]  sh_shift_type;
  logic [4:0]  sh_shift_imm;
  logic        sh_carry_in;
  logic [31:0] sh_operand = 0;
  logic        sh_carry_out = 0;
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  shift_operand_ctrl dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_rm(req_rm), .req_type(req_type), .req_is_reg(req_is_reg), .req_imm(req_imm),
    .req_rs_amt(req_rs_amt), .req_carry(req_carry), .out_valid(out_valid),
    .out_ready(out_ready), .out_operand(out_operand), .out_carry(out_carry),
    .sh_shift_in(sh_shift_in), .sh_shift_type(sh_shift_type), .sh_shift_imm(sh_shift_imm),
    .sh_carry_in(sh_carry_in), .sh_operand(sh_operand), .sh_carry_out(sh_carry_out)
  );

  // Registered ARM immediate-form barrel shifter (amount 0 = LSL#0 / LSR#32 / ASR#32 / RRX)
  always @(posedge clk) begin
    int n;
    n = int'(sh_shift_imm);
    case (sh_shift_type)
      2'b00: begin
        sh_operand   <= sh_shift_in << n;
        sh_carry_out <= n == 0 ? sh_carry_in : sh_shift_in[32-n];
      end
      2'b01: begin
        sh_operand   <= n == 0 ? 32'h0 : sh_shift_in >> n;
        sh_carry_out <= n == 0 ? sh_shift_in[31] : sh_shift_in[n-1];
      end
      2'b10: begin
        sh_operand   <= n == 0 ? {32{sh_shift_in[31]}} : 32'($signed(sh_shift_in) >>> n);
        sh_carry_out <= n == 0 ? sh_shift_in[31] : sh_shift_in[n-1];
      end
      default: begin
        sh_operand   <= n == 0 ? {sh_carry_in, sh_shift_in[31:1]} : (sh_shift_in >> n) | (sh_shift_in << (32 - n));
        sh_carry_out <= n == 0 ? sh_shift_in[0] : sh_shift_in[n-1];
      end
    endcase
  end

  task automatic issue(input logic [31:0] rm, input logic [1:0] ty, input logic is_reg,
                       input logic [4:0] imm, input logic [7:0] rs, input logic c,
                       output int lat);
    @(negedge clk);
    req_rm = rm; req_type = ty; req_is_reg = is_reg; req_imm = imm; req_rs_amt = rs; req_carry = c;
    req_valid = 1;
    @(posedge clk);
    #1 req_valid = 0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 10);
  endtask

  task automatic retire();
    @(negedge clk);
    out_ready = 1;
    @(posedge clk);
    #1 out_ready = 0;
  endtask

  task automatic run(input string name, input logic [31:0] rm, input logic [1:0] ty, input logic is_reg,
                     input logic [4:0] imm, input logic [7:0] rs, input logic c,
                     input logic [31:0] eop, input logic ec, input int elat);
    int lat;
    issue(rm, ty, is_reg, imm, rs, c, lat);
    tests++;
    if (lat !== elat) begin fails++; $display("FAIL %s latency got %0d want %0d", name, lat, elat); end
    tests++;
    if (out_operand !== eop) begin fails++; $display("FAIL %s operand got %h want %h", name, out_operand, eop); end
    tests++;
    if (out_carry !== ec) begin fails++; $display("FAIL %s carry got %b want %b", name, out_carry, ec); end
    retire();
  endtask

  task automatic test_reset();
    @(negedge clk);
    tests++;
    if ({req_ready, out_valid, out_carry} !== 3'b100) begin
      fails++; $display("FAIL reset ready/valid/carry got %b want 100", {req_ready, out_valid, out_carry});
    end
    tests++;
    if (out_operand !== 32'h0) begin fails++; $display("FAIL reset operand got %h want 0", out_operand); end
    tests++;
    if ({sh_shift_in, sh_shift_type, sh_shift_imm, sh_carry_in} !== 40'h0) begin
      fails++; $display("FAIL reset sh_outputs got %h want 0", {sh_shift_in, sh_shift_type, sh_shift_imm, sh_carry_in});
    end
  endtask

  task automatic test_imm();
    run("imm_lsr4",  32'h8000_00F0, 2'b01, 0, 5'd4, 8'd0, 0, 32'h0800_000F, 0, 3);
    run("imm_lsl0",  32'h1234_5678, 2'b00, 0, 5'd0, 8'd0, 1, 32'h1234_5678, 1, 1);
    run("imm_lsr0",  32'h8000_0000, 2'b01, 0, 5'd0, 8'd0, 0, 32'h0, 1, 3);
    run("imm_asr0",  32'h8000_0000, 2'b10, 0, 5'd0, 8'd0, 0, 32'hFFFF_FFFF, 1, 3);
  endtask

  task automatic test_reg_boundary();
    run("reg_lsl32", 32'h0000_0001, 2'b00, 1, 5'd0, 8'd32, 0, 32'h0, 1, 1);
    run("reg_lsl33", 32'h0000_0001, 2'b00, 1, 5'd0, 8'd33, 1, 32'h0, 0, 1);
    run("reg_lsr32", 32'h8000_0000, 2'b01, 1, 5'd0, 8'd32, 0, 32'h0, 1, 1);
    run("reg_asr200",32'h8000_0000, 2'b10, 1, 5'd0, 8'd200, 0, 32'hFFFF_FFFF, 1, 1);
    run("reg_ror64", 32'h8000_0001, 2'b11, 1, 5'd0, 8'd64, 0, 32'h8000_0001, 1, 1);
    run("reg_amt0",  32'h0000_0005, 2'b11, 1, 5'd7, 8'd0, 0, 32'h0000_0005, 0, 1);
  endtask

  task automatic test_reg_shifter();
    run("reg_lsl4",  32'hF000_000F, 2'b00, 1, 5'd0, 8'd4, 0, 32'h0000_00F0, 1, 3);
    run("reg_ror36", 32'h0000_000F, 2'b11, 1, 5'd0, 8'd36, 0, 32'hF000_0000, 1, 3);
    tests++;
    if (sh_shift_imm !== 5'd4) begin fails++; $display("FAIL ror36 sh_shift_imm got %0d want 4", sh_shift_imm); end
  endtask

  task automatic test_rrx();
    run("imm_rrx", 32'h0000_0003, 2'b11, 0, 5'd0, 8'd0, 1, 32'h8000_0001, 1, 3);
  endtask

  task automatic test_backpressure();
    int lat;
    issue(32'h0000_00F0, 2'b01, 0, 5'd4, 8'd0, 1, lat);
    for (int i = 0; i < 5; i++) begin
      tests++;
      if ({out_valid, req_ready, out_operand, out_carry} !== {2'b10, 32'h0000_000F, 1'b0}) begin
        fails++;
        $display("FAIL hold cycle %0d valid/ready/op/c got %b%b %h %b want 10 0000000f 0",
                 i, out_valid, req_ready, out_operand, out_carry);
      end
      @(negedge clk);
    end
    out_ready = 1;
    tests++;
    if (req_ready !== 1'b0) begin fails++; $display("FAIL retire_cycle req_ready got %b want 0", req_ready); end
    @(posedge clk);
    #1 out_ready = 0;
    @(negedge clk);
    tests++;
    if ({out_valid, req_ready} !== 2'b01) begin
      fails++; $display("FAIL release valid/ready got %b%b want 01", out_valid, req_ready);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    req_rm = 32'h0000_0100; req_type = 2'b01; req_is_reg = 1; req_rs_amt = 8'd8; req_carry = 0;
    req_valid = 1;
    @(posedge clk);
    #1 req_valid = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    tests++;
    if ({out_valid, req_ready, out_carry} !== 3'b010 || out_operand !== 32'h0 || sh_shift_in !== 32'h0) begin
      fails++;
      $display("FAIL mid_reset valid/ready/c/op/sh got %b%b%b %h %h want 010 0 0",
               out_valid, req_ready, out_carry, out_operand, sh_shift_in);
    end
    rst_n = 1;
    run("post_reset", 32'h0000_0100, 2'b01, 1, 5'd0, 8'd8, 0, 32'h0000_0001, 0, 3);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    test_reset();
    test_imm();
    test_reg_boundary();
    test_reg_shifter();
    test_rrx();
    test_backpressure();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
